data_mem_master: RTL and testbench
==================================

DATA_MEM_MASTER -- requirements
Module: data_mem_master

Interface
REQ-001 SHALL have parameter: MEM_RD_LAT, 1, data-memory read latency in cycles (legal 0..7).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  1  requester has a transaction.
REQ-005 SHALL have port: req_ready  output  1  block can accept a transaction.
REQ-006 SHALL have port: req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: req_addr  input  8  target address.
REQ-008 SHALL have port: req_wdata  input  8  write data.
REQ-009 SHALL have port: rsp_valid  output  1  read data available.
REQ-010 SHALL have port: rsp_ready  input  1  requester takes the response.
REQ-011 SHALL have port: rsp_rdata  output  8  read data.
REQ-012 SHALL have port: mem_adr  output  8  to memory adr.
REQ-013 SHALL have port: mem_datain  output  8  to memory datain.
REQ-014 SHALL have port: mem_w  output  1  to memory w.
REQ-015 SHALL have port: mem_r  output  1  to memory r.
REQ-016 SHALL have port: mem_dataout  input  8  from memory dataout.
REQ-017 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port: vfy_err  output  1  sticky write-verify mismatch flag.

Function
REQ-019 SHALL implement FSM states IDLE, WR, RD, RESP; all outputs registered or decoded from state only.
REQ-020 SHALL assert req_ready only in IDLE; accept when req_valid && req_ready at the clock edge, latching addr, wdata, we.
REQ-021 SHALL transition IDLE->WR on an accepted write and IDLE->RD on an accepted read.
REQ-022 SHALL drive mem_w=1 for exactly one cycle in WR, with mem_adr/mem_datain equal to the latched values; WR->IDLE next edge.
REQ-023 SHALL hold mem_r=1 throughout RD, clearing the latency counter on entry, and increment it each cycle.
REQ-024 SHALL capture mem_dataout into rsp_rdata and move to RESP on the edge where counter == MEM_RD_LAT (read occupies MEM_RD_LAT+1 cycles).
REQ-025 SHALL hold rsp_valid=1 and rsp_rdata stable in RESP until rsp_valid && rsp_ready; RESP->IDLE on that edge.
REQ-026 SHALL never assert mem_w and mem_r together; both 0 in IDLE and RESP.
REQ-027 SHALL keep mem_adr at its last driven value in IDLE/RESP.
REQ-028 SHALL ignore req_valid outside IDLE; a request arriving while the response handshake completes is accepted no earlier than the next cycle (IDLE).
REQ-029 SHALL size the latency counter at 3 bits with no wrap (saturates at MEM_RD_LAT).

Reset
REQ-030 SHALL on rst_n low immediately force state IDLE and outputs req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, mem_adr=0, mem_datain=0, mem_w=0, mem_r=0, busy=0, vfy_err=0.
REQ-031 SHALL abandon any in-flight transaction on reset without issuing a response.

Configuration
REQ-032 SHALL, with DATA_MEM_VERIFY_EN defined, follow every WR with an RD of the same address (no response issued) and set vfy_err when captured data differs from written data; WR->RD->IDLE.
REQ-033 SHALL, without DATA_MEM_VERIFY_EN, tie vfy_err to 0 and omit the verify path.

Structure
REQ-034 SHALL take state enum, ADDR_W=8, DATA_W=8 from shared package data_mem_pkg.
REQ-035 SHALL be one flat module; no sub-module.

Verification
REQ-036 SHALL cover: write 0x0A<=0x55 -> one cycle mem_w=1, mem_adr=0x0A, mem_datain=0x55; req_ready high again 2 cycles after accept.
REQ-037 SHALL cover: read 0x0A after that write (MEM_RD_LAT=1) -> mem_r high 2 cycles, rsp_valid 3 cycles after accept with rsp_rdata=0x55.
REQ-038 SHALL cover: rsp_ready held low 4 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored.
REQ-039 SHALL cover: rst_n low during RD -> mem_r=0, rsp_valid=0 immediately; no response after release.
REQ-040 SHALL cover: DATA_MEM_VERIFY_EN with memory forced to return 0x00 on write 0xFF -> vfy_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared widths and FSM state encoding for the data-memory master
package data_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WR   = 2'd1;
  localparam state_t ST_RD   = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - single-outstanding data-memory master; DATA_MEM_VERIFY_EN adds write read-back verify
module data_mem_master
  import data_mem_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy,
  output logic              vfy_err
);

  localparam logic [2:0] LAT_C = 3'(MEM_RD_LAT);

  state_t     state;
  logic [2:0] lat_cnt;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign mem_w     = (state == ST_WR);
  assign mem_r     = (state == ST_RD);
  assign rsp_valid = (state == ST_RESP);

`ifdef DATA_MEM_VERIFY_EN
  // Set while the current RD is the read-back of a write: compare instead of responding.
  logic vfy_rd;
  logic vfy_err_q;
  assign vfy_err = vfy_err_q;
`else
  assign vfy_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= 3'd0;
      rsp_rdata  <= '0;
      mem_adr    <= '0;
      mem_datain <= '0;
`ifdef DATA_MEM_VERIFY_EN
      vfy_rd     <= 1'b0;
      vfy_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_adr <= req_addr;
            if (req_we) begin
              mem_datain <= req_wdata;
              state      <= ST_WR;
            end else begin
              lat_cnt <= 3'd0;
              state   <= ST_RD;
`ifdef DATA_MEM_VERIFY_EN
              vfy_rd  <= 1'b0;
`endif
            end
          end
        end
        ST_WR: begin
`ifdef DATA_MEM_VERIFY_EN
          lat_cnt <= 3'd0;
          vfy_rd  <= 1'b1;
          state   <= ST_RD;
`else
          state   <= ST_IDLE;
`endif
        end
        ST_RD: begin
          if (lat_cnt == LAT_C) begin
`ifdef DATA_MEM_VERIFY_EN
            if (vfy_rd) begin
              if (mem_dataout != mem_datain) vfy_err_q <= 1'b1;
              state <= ST_IDLE;
            end else begin
              rsp_rdata <= mem_dataout;
              state     <= ST_RESP;
            end
`else
            rsp_rdata <= mem_dataout;
            state     <= ST_RESP;
`endif
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - scoreboard bench for data_mem_master; honours DATA_MEM_VERIFY_EN
module tb_data_mem_master;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_adr;
  logic [7:0] mem_datain;
  logic       mem_w;
  logic       mem_r;
  logic [7:0] mem_dataout;
  logic       busy;
  logic       vfy_err;

  logic       rand_rdy = 1'b0;
  logic       rnd_rdy = 1'b0;
  logic       dir_rdy = 1'b0;
  logic       force_zero = 1'b0;
  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];

  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  int tests = 0;
  int fails = 0;

  assign rsp_ready   = rand_rdy ? rnd_rdy : dir_rdy;
  assign mem_dataout = force_zero ? 8'h00 : mem_arr[mem_adr];

  data_mem_master #(.MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
    .mem_dataout(mem_dataout), .busy(busy), .vfy_err(vfy_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_w) mem_arr[mem_adr] <= mem_datain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request and records its expected effects in the reference memory and queues.
  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("issue_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (we) begin
      wr_q.push_back({a, d});
      ref_mem[a] = d;
    end else begin
      rd_q.push_back(ref_mem[a]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every memory write, read pulse length and response is checked against expectations.
  logic       prev_w = 1'b0, prev_r = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_rdata = 8'h00;
  int         r_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_w = 1'b0; prev_r = 1'b0; prev_hold = 1'b0; r_run = 0;
    end else begin
      chk("w_and_r_exclusive", {31'd0, mem_w & mem_r}, 0);
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
      if (mem_w) begin
        chk("mem_w_single_cycle", {31'd0, prev_w}, 0);
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          logic [15:0] e;
          e = wr_q.pop_front();
          chk("mem_adr_wr", {24'd0, mem_adr}, {24'd0, e[15:8]});
          chk("mem_datain_wr", {24'd0, mem_datain}, {24'd0, e[7:0]});
        end
      end
      if (mem_r) r_run++;
      else if (prev_r) begin
        chk("mem_r_cycles", r_run, LAT + 1);
        r_run = 0;
      end
      if (prev_hold) begin
        chk("rsp_valid_held", {31'd0, rsp_valid}, 1);
        chk("rsp_rdata_stable", {24'd0, rsp_rdata}, {24'd0, prev_rdata});
      end
      if (rsp_valid && rsp_ready) begin
        if (rd_q.size() == 0) chk("unexpected_response", 1, 0);
        else chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, rd_q.pop_front()});
      end
      prev_w = mem_w;
      prev_r = mem_r;
      prev_hold = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin mem_arr[i] = 8'h00; ref_mem[i] = 8'h00; end

    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
    chk("rst_mem_adr", {24'd0, mem_adr}, 0);
    chk("rst_mem_datain", {24'd0, mem_datain}, 0);
    chk("rst_mem_w_r", {30'd0, mem_w, mem_r}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_vfy_err", {31'd0, vfy_err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 1);

    // Write 0x0A <= 0x55 then count how long req_ready stays low.
    issue(1'b1, 8'h0A, 8'h55);
    @(negedge clk);
    chk("wr_mem_w", {31'd0, mem_w}, 1);
    chk("wr_ready_low", {31'd0, req_ready}, 0);
    n = 0;
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
`ifdef DATA_MEM_VERIFY_EN
    chk("wr_busy_cycles", n, 1 + LAT + 1);
`else
    chk("wr_busy_cycles", n, 1);
`endif

    // Read back with response stalled: latency, then held response ignores new requests.
    issue(1'b0, 8'h0A, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk("rd_latency", n, LAT + 2);
    chk("rd_data_direct", {24'd0, rsp_rdata}, 8'h55);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_wdata = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("stall_rsp_rdata", {24'd0, rsp_rdata}, 8'h55);
      chk("stall_req_ready", {31'd0, req_ready}, 0);
      chk("stall_no_write", {31'd0, mem_w}, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; dir_rdy = 1'b1;
    @(posedge clk); #1 dir_rdy = 1'b0;
    @(negedge clk);
    chk("rsp_done", {31'd0, rsp_valid}, 0);

    // Reset in the middle of a read: response abandoned.
    issue(1'b0, 8'h0A, 8'h00);
    @(negedge clk);
    chk("rd_mem_r", {31'd0, mem_r}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrd_mem_r", {31'd0, mem_r}, 0);
    chk("rstrd_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rstrd_mem_adr", {24'd0, mem_adr}, 0);
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; dir_rdy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rstrd_no_rsp", {31'd0, rsp_valid}, 0);
    end
    dir_rdy = 1'b0;

`ifdef DATA_MEM_VERIFY_EN
    force_zero = 1'b1;
    issue(1'b1, 8'h21, 8'hFF);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    force_zero = 1'b0;
    chk("vfy_err_set", {31'd0, vfy_err}, 1);
    repeat (5) @(negedge clk);
    chk("vfy_err_sticky", {31'd0, vfy_err}, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("vfy_err_cleared", {31'd0, vfy_err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    rand_rdy = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 15));
      issue(($urandom_range(0, 1) == 1), a, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    n = 0;
    while ((busy || rd_q.size() != 0 || wr_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain", n < 200, 1);
    chk("final_vfy_err", {31'd0, vfy_err}, 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
